aq_shift_reg: RTL and testbench

Parametrised A/Q register pair for the iterative multiplier/divider datapath. It holds {A,Q} as one 2*WIDTH-bit word and has parallel load and a gated output. It adds a per-step A-writeback and shift engine: arithmetic shift right (Booth multiply) or shift left with quotient-bit insert (restoring divide). A step counter sequences STEPS iterations and flags completion to the controller.

---
 rtl/aq_shift_reg_if.sv | 33 +++
 rtl/aq_shift_reg.sv | 114 +++++++++++
 tb/tb_aq_shift_reg.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/aq_shift_reg_if.sv
// Bus interface for the A/Q shift register: load, step control and result.
// Controller/datapath side uses master; the register block uses slave.
interface aq_shift_reg_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = WIDTH
);
  localparam int unsigned CW = $clog2(STEPS + 1);
  localparam int unsigned DW = 2 * WIDTH;

  logic          load_en;
  logic [DW-1:0] load_data;
  logic          start;
  logic          op;
  logic          a_wr_en;
  logic [WIDTH-1:0] a_wr_data;
  logic          q0_in;
  logic          out_en;
  logic [DW-1:0] out;
  logic          q_m1;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  modport master (
    output load_en, load_data, start, op, a_wr_en, a_wr_data, q0_in, out_en,
    input  out, q_m1, busy, done, count
  );

  modport slave (
    input  load_en, load_data, start, op, a_wr_en, a_wr_data, q0_in, out_en,
    output out, q_m1, busy, done, count
  );
endinterface

// File: rtl/aq_shift_reg.sv
// A/Q register pair for the iterative multiplier/divider datapath.
// Holds {A,Q}, supports parallel load, per-step A writeback, and either an
// arithmetic right shift (Booth multiply, with Q[-1]) or a left shift with
// quotient-bit insert (restoring divide). A step counter runs STEPS
// iterations and pulses done on the last one.
// Optional macro AQ_TRISTATE_EN: out floats to 'z when out_en=0 instead of 0.
module aq_shift_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = WIDTH
) (
  input  logic clk,
  input  logic reset,
  aq_shift_reg_if.slave bus
);
  localparam int unsigned CW = $clog2(STEPS + 1);
  localparam int unsigned DW = 2 * WIDTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_aq;
  logic [DW-1:0]   w_aq_nxt;
  logic            r_qm1;
  logic            w_qm1_nxt;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic            r_op;
  logic            w_op_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic [DW-1:0]   w_merge;
  logic            w_last;

  // A is optionally replaced by the datapath result before the shift
  assign w_merge = {(bus.a_wr_en ? bus.a_wr_data : r_aq[DW-1:WIDTH]), r_aq[WIDTH-1:0]};
  assign w_last  = (r_count == CW'(STEPS - 1));

  // Next-state and datapath update: load > start (idle) > step > hold
  always_comb begin
    w_state_nxt = r_state;
    w_aq_nxt    = r_aq;
    w_qm1_nxt   = r_qm1;
    w_count_nxt = r_count;
    w_op_nxt    = r_op;
    w_done_nxt  = 1'b0;

    if (bus.load_en) begin
      w_aq_nxt    = bus.load_data;
      w_qm1_nxt   = 1'b0;
      w_count_nxt = '0;
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_state_nxt = S_RUN;
            w_op_nxt    = bus.op;
            w_count_nxt = '0;
          end
        end
        S_RUN: begin
          if (!r_op) begin
            w_aq_nxt  = {w_merge[DW-1], w_merge[DW-1:1]};
            w_qm1_nxt = w_merge[0];
          end else begin
            w_aq_nxt  = {w_merge[DW-2:0], bus.q0_in};
          end
          w_count_nxt = r_count + CW'(1);
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_aq    <= '0;
      r_qm1   <= 1'b0;
      r_count <= '0;
      r_op    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_aq    <= w_aq_nxt;
      r_qm1   <= w_qm1_nxt;
      r_count <= w_count_nxt;
      r_op    <= w_op_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.q_m1  = r_qm1;
  assign bus.busy  = (r_state == S_RUN);
  assign bus.done  = r_done;
  assign bus.count = r_count;

  // Result bus gate: out_en acts combinationally
`ifdef AQ_TRISTATE_EN
  assign bus.out = bus.out_en ? r_aq : {DW{1'bz}};
`else
  assign bus.out = bus.out_en ? r_aq : '0;
`endif

endmodule

// File: tb/tb_aq_shift_reg.sv
// Bench for aq_shift_reg (WIDTH=32, STEPS=32): directed scenarios followed by
// randomized traffic, compared each cycle against a behavioural model.
module tb_aq_shift_reg;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned STEPS = 32;

  logic clk;
  logic reset;

  aq_shift_reg_if #(.WIDTH(WIDTH), .STEPS(STEPS)) bus ();

  aq_shift_reg #(.WIDTH(WIDTH), .STEPS(STEPS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // behavioural model state
  logic [63:0] m_aq;
  logic        m_qm1;
  int          m_cnt;
  bit          m_run;
  logic        m_op;
  logic        m_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_out();
`ifdef AQ_TRISTATE_EN
    return bus.out_en ? m_aq : {64{1'bz}};
`else
    return bus.out_en ? m_aq : 64'h0;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".out"},   bus.out,          exp_out());
    chk({tag, ".q_m1"},  64'(bus.q_m1),    64'(m_qm1));
    chk({tag, ".busy"},  64'(bus.busy),    64'(m_run));
    chk({tag, ".done"},  64'(bus.done),    64'(m_done));
    chk({tag, ".count"}, 64'(bus.count),   64'(m_cnt));
  endtask

  task automatic model_reset();
    m_aq = '0; m_qm1 = 1'b0; m_cnt = 0; m_run = 1'b0; m_op = 1'b0; m_done = 1'b0;
  endtask

  // Advance one clock: predict from current inputs, then check after the edge
  task automatic tick(input string tag);
    logic [63:0] merge, n_aq;
    logic        n_qm1, n_op, n_done;
    int          n_cnt;
    bit          n_run;
    n_aq = m_aq; n_qm1 = m_qm1; n_cnt = m_cnt; n_run = m_run; n_op = m_op; n_done = 1'b0;
    if (!reset) begin
      n_aq = '0; n_qm1 = 1'b0; n_cnt = 0; n_run = 1'b0; n_op = 1'b0;
    end else if (bus.load_en) begin
      n_aq = bus.load_data; n_qm1 = 1'b0; n_cnt = 0; n_run = 1'b0;
    end else if (!m_run) begin
      if (bus.start) begin
        n_run = 1'b1; n_op = bus.op; n_cnt = 0;
      end
    end else begin
      merge = bus.a_wr_en ? {bus.a_wr_data, m_aq[31:0]} : m_aq;
      if (!m_op) begin
        n_aq  = 64'($signed(merge) >>> 1);
        n_qm1 = merge[0];
      end else begin
        n_aq = (merge << 1) | 64'(bus.q0_in);
      end
      n_cnt = m_cnt + 1;
      if (n_cnt == int'(STEPS)) begin
        n_run = 1'b0; n_done = 1'b1;
      end
    end
    @(posedge clk);
    m_aq = n_aq; m_qm1 = n_qm1; m_cnt = n_cnt; m_run = n_run; m_op = n_op; m_done = n_done;
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.load_en = 1'b0; bus.load_data = '0; bus.start = 1'b0; bus.op = 1'b0;
    bus.a_wr_en = 1'b0; bus.a_wr_data = '0; bus.q0_in = 1'b0;
  endtask

  initial begin
    int done_seen;
    logic [63:0] e_div;

    idle_inputs();
    bus.out_en = 1'b1;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("rst_init");
    #3 reset = 1'b1;
    tick("rst_hold");

    // async reset mid-cycle clears a loaded value immediately
    bus.load_en = 1'b1; bus.load_data = 64'hDEAD_BEEF_0123_4567;
    tick("pre_rst_load");
    bus.load_en = 1'b0;
    #3 reset = 1'b0;
    #1 model_reset();
    check_all("rst_async");
    chk("rst_async_out", bus.out, 64'h0);
    #2 reset = 1'b1;
    tick("rst_release");

    // load with output disabled, then enable
    bus.load_en = 1'b1; bus.load_data = 64'h0000_0000_FFFF_FFF6; bus.out_en = 1'b0;
    tick("load_oe0");
    bus.load_en = 1'b0; bus.out_en = 1'b1;
    #1 chk("load_oe1", bus.out, 64'h0000_0000_FFFF_FFF6);

    // Booth-style multiply run, no writeback
    bus.load_en = 1'b1; bus.load_data = 64'h8000_0000_0000_0003;
    tick("mul_load");
    bus.load_en = 1'b0; bus.start = 1'b1; bus.op = 1'b0;
    tick("mul_start");
    bus.start = 1'b0;
    tick("mul_step1");
    chk("mul_step1_out", bus.out, 64'hC000_0000_0000_0001);
    chk("mul_step1_qm1", 64'(bus.q_m1), 64'd1);
    done_seen = 0;
    for (int k = 2; k <= 32; k++) begin
      tick("mul_step");
      if (bus.done === 1'b1) done_seen++;
    end
    chk("mul_done_pulses", 64'(done_seen), 64'd1);
    chk("mul_final_out", bus.out, 64'hFFFF_FFFF_8000_0000);
    chk("mul_final_cnt", 64'(bus.count), 64'd32);
    chk("mul_final_busy", 64'(bus.busy), 64'd0);
    tick("mul_after");
    chk("mul_cnt_hold", 64'(bus.count), 64'd32);

    // restoring divide 7 / 2
    bus.load_en = 1'b1; bus.load_data = {32'h0, 32'h0000_0007};
    tick("div_load");
    bus.load_en = 1'b0; bus.start = 1'b1; bus.op = 1'b1;
    tick("div_start");
    bus.start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      // shifted A minus 2 keeps the inserted bit, so write back A-1 pre-shift
      bus.a_wr_en = 1'b1;
      if (m_aq[62:31] >= 32'd2) begin
        bus.a_wr_data = m_aq[63:32] - 32'd1; bus.q0_in = 1'b1;
      end else begin
        bus.a_wr_data = m_aq[63:32];         bus.q0_in = 1'b0;
      end
      tick("div_step");
    end
    idle_inputs();
    e_div = {32'(7 % 2), 32'(7 / 2)};
    chk("div_result", bus.out, e_div);
    chk("div_done", 64'(bus.done), 64'd1);

    // writeback merge on a multiply step
    bus.load_en = 1'b1; bus.load_data = 64'h1234_5678_FFFF_FFFF;
    tick("wb_load");
    bus.load_en = 1'b0; bus.start = 1'b1; bus.op = 1'b0;
    tick("wb_start");
    bus.start = 1'b0; bus.a_wr_en = 1'b1; bus.a_wr_data = 32'hF000_0000;
    tick("wb_step");
    chk("wb_out", bus.out, 64'hF800_0000_7FFF_FFFF);
    chk("wb_qm1", 64'(bus.q_m1), 64'd1);
    idle_inputs();
    bus.load_en = 1'b1;
    tick("wb_abort");

    // start mid-run ignored, load at count 10 aborts
    bus.load_en = 1'b0; bus.start = 1'b1; bus.op = 1'b1;
    tick("ab_start");
    bus.start = 1'b0;
    repeat (4) tick("ab_run");
    bus.start = 1'b1;
    tick("ab_restart");
    chk("ab_restart_cnt", 64'(bus.count), 64'd5);
    bus.start = 1'b0;
    repeat (5) tick("ab_run2");
    chk("ab_cnt10", 64'(bus.count), 64'd10);
    bus.load_en = 1'b1; bus.load_data = 64'h0F0F_0F0F_F0F0_F0F0;
    tick("ab_load");
    chk("ab_busy", 64'(bus.busy), 64'd0);
    chk("ab_done", 64'(bus.done), 64'd0);
    bus.load_en = 1'b0;
    tick("ab_idle");

    // reset at count 5
    bus.start = 1'b1; bus.op = 1'b0;
    tick("rs_start");
    bus.start = 1'b0;
    repeat (5) tick("rs_run");
    #3 reset = 1'b0;
    #1 model_reset();
    check_all("rs_async");
    tick("rs_held");
    #3 reset = 1'b1;
    tick("rs_release");

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      bus.load_en   = ($urandom_range(0, 39) == 0);
      bus.load_data = {$urandom(), $urandom()};
      bus.start     = ($urandom_range(0, 7) == 0);
      bus.op        = 1'($urandom_range(0, 1));
      bus.a_wr_en   = 1'($urandom_range(0, 1));
      bus.a_wr_data = $urandom();
      bus.q0_in     = 1'($urandom_range(0, 1));
      bus.out_en    = ($urandom_range(0, 7) != 0);
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
